// File: rtl/sar_pkg.sv
// sar_pkg: shared types and constants for the SAR ADC result path.
//   SAR_N_BITS       - ADC result width
//   SAR_LOG2_AVG_MAX - largest supported log2 averaging factor
//   sar_result_t     - one ADC conversion result
//   acc_width()      - accumulator width that cannot overflow for 2^log2_avg samples
package sar_pkg;

   localparam int SAR_N_BITS       = 10;
   localparam int SAR_LOG2_AVG_MAX = 6;

   typedef logic [SAR_N_BITS-1:0] sar_result_t;

   function automatic int acc_width(input int n_bits, input int log2_avg);
      return n_bits + log2_avg;
   endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// sar_result_fifo: small synchronous FIFO, power-of-two depth.
//   clk, rst_n      - clock, asynchronous active-low reset
//   push, push_data - write request; accepted when not full or when popping
//   pop             - read request; ignored when empty
//   head_data       - entry at the read pointer (zero after reset)
//   full, empty     - occupancy flags
module sar_result_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]              count_q, count_d;
   logic                        wr_en, rd_en;

   assign full      = (count_q == (PTR_W+1)'(DEPTH));
   assign empty     = (count_q == '0);
   assign head_data = mem_q[rd_ptr_q];

   always_comb begin
      rd_en    = pop & ~empty;
      // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
      wr_en    = push & (~full | rd_en);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/sar_result_averager.sv
// sar_result_averager: captures SAR ADC results on each eoc rising edge,
// box-car averages 2^LOG2_AVG of them with rounding, and queues the averages.
//   clk, reset          - system clock, asynchronous active-low reset
//   enable              - 0 discards the in-progress average and ignores eoc
//   adc_eoc             - ADC end-of-conversion level (clk-synchronous)
//   adc_result_digital  - ADC result, valid while adc_eoc is high
//   avg_result_digital  - average at the FIFO head
//   avg_valid/avg_ready - output handshake
//   overflow            - sticky, an average was dropped on a full FIFO
//   clear_overflow      - synchronous clear of overflow (a new drop wins)
//   sample_count        - samples accumulated toward the current average
module sar_result_averager
   import sar_pkg::*;
#(
   parameter int N_BITS     = SAR_N_BITS,
   parameter int LOG2_AVG   = 2,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic                adc_eoc,
   input  logic [N_BITS-1:0]   adc_result_digital,
   output logic [N_BITS-1:0]   avg_result_digital,
   output logic                avg_valid,
   input  logic                avg_ready,
   output logic                overflow,
   input  logic                clear_overflow,
   output logic [LOG2_AVG:0]   sample_count
);

   localparam int ACC_W = acc_width(N_BITS, LOG2_AVG);
   localparam int CNT_W = LOG2_AVG + 1;
   localparam logic [CNT_W-1:0] LAST    = CNT_W'((2**LOG2_AVG) - 1);
   // Half an LSB of the result; (2**0)/2 == 0 gives plain pass-through.
   localparam logic [ACC_W:0]   ROUND   = (ACC_W+1)'((2**LOG2_AVG) / 2);
   localparam logic [ACC_W:0]   MAX_AVG = (ACC_W+1)'((2**N_BITS) - 1);

   logic              eoc_q, eoc_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  sample_count_q, sample_count_d;
   logic              overflow_q, overflow_d;
   logic              capture, complete, pop, fifo_push, drop;
   logic              fifo_full, fifo_empty;
   logic [ACC_W:0]    sum_rnd, avg_wide;
   logic [N_BITS-1:0] avg;

   always_comb begin
      eoc_d     = adc_eoc;
      capture   = adc_eoc & ~eoc_q & enable;
      complete  = capture & (sample_count_q == LAST);
      // One spare bit so the rounding add can never wrap before the clamp.
      sum_rnd   = {1'b0, acc_q} + (ACC_W+1)'(adc_result_digital) + ROUND;
      avg_wide  = sum_rnd >> LOG2_AVG;
      avg       = (avg_wide > MAX_AVG) ? MAX_AVG[N_BITS-1:0] : avg_wide[N_BITS-1:0];

      acc_d          = acc_q;
      sample_count_d = sample_count_q;
      if (!enable) begin
         acc_d          = '0;
         sample_count_d = '0;
      end else if (capture) begin
         if (complete) begin
            acc_d          = '0;
            sample_count_d = '0;
         end else begin
            acc_d          = acc_q + ACC_W'(adc_result_digital);
            sample_count_d = sample_count_q + CNT_W'(1);
         end
      end

      pop        = ~fifo_empty & avg_ready;
      fifo_push  = complete & (~fifo_full | pop);
      drop       = complete & fifo_full & ~pop;
      overflow_d = drop | (overflow_q & ~clear_overflow);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         eoc_q          <= 1'b0;
         acc_q          <= '0;
         sample_count_q <= '0;
         overflow_q     <= 1'b0;
      end else begin
         eoc_q          <= eoc_d;
         acc_q          <= acc_d;
         sample_count_q <= sample_count_d;
         overflow_q     <= overflow_d;
      end
   end

   sar_result_fifo #(
      .WIDTH (N_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .push      (fifo_push),
      .push_data (avg),
      .pop       (pop),
      .head_data (avg_result_digital),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign avg_valid    = ~fifo_empty;
   assign overflow     = overflow_q;
   assign sample_count = sample_count_q;

endmodule

// File: tb/tb_sar_result_averager.sv
// Testbench for sar_result_averager (LOG2_AVG=2, FIFO_DEPTH=2).
// Stimulus pushes hand-computed averages into exp_q; a negedge monitor pops
// and compares each time the DUT hands over an output.
module tb_sar_result_averager;
   import sar_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b1;
   logic        adc_eoc = 1'b0;
   logic [9:0]  adc_result_digital = '0;
   logic [9:0]  avg_result_digital;
   logic        avg_valid;
   logic        avg_ready = 1'b1;
   logic        overflow;
   logic        clear_overflow = 1'b0;
   logic [2:0]  sample_count;

   int tests = 0;
   int fails = 0;
   sar_result_t exp_q[$];

   sar_result_averager #(.N_BITS(10), .LOG2_AVG(2), .FIFO_DEPTH(2)) dut (
      .clk                (clk),
      .reset              (reset),
      .enable             (enable),
      .adc_eoc            (adc_eoc),
      .adc_result_digital (adc_result_digital),
      .avg_result_digital (avg_result_digital),
      .avg_valid          (avg_valid),
      .avg_ready          (avg_ready),
      .overflow           (overflow),
      .clear_overflow     (clear_overflow),
      .sample_count       (sample_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic conv(input logic [9:0] v, input int hi, input int lo);
      adc_result_digital = v;
      adc_eoc = 1'b1;
      tick(hi);
      adc_eoc = 1'b0;
      tick(lo);
   endtask

   // Monitor: every cycle with valid & ready is one handed-over average.
   always @(negedge clk) begin
      if (reset && avg_valid && avg_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got %0d expected none", avg_result_digital);
         end else begin
            sar_result_t e;
            e = exp_q.pop_front();
            check("avg_out", int'(avg_result_digital), int'(e));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int vals[4] = '{100, 101, 102, 103};
      int cnts[4] = '{1, 2, 3, 0};

      // reset state
      #12;
      check("rst_valid", avg_valid, 0);
      check("rst_result", avg_result_digital, 0);
      check("rst_overflow", overflow, 0);
      check("rst_count", sample_count, 0);
      @(negedge clk) reset = 1'b1;
      tick(2);

      // 1: basic average 100..103 -> 102, sample_count 1,2,3,0, latency
      exp_q.push_back(10'd102);
      for (int i = 0; i < 4; i++) begin
         adc_result_digital = 10'(vals[i]);
         adc_eoc = 1'b1;
         if (i == 3) check("t1_valid_before", avg_valid, 0);
         tick(1);
         check("t1_count", sample_count, cnts[i]);
         if (i == 3) check("t1_valid_after", avg_valid, 1);
         adc_eoc = 1'b0;
         tick(2);
      end
      tick(2);

      // 2: long eoc levels give one capture each
      exp_q.push_back(10'd512);
      for (int i = 0; i < 4; i++) begin
         conv(10'd512, 18, 3);
         check("t2_count", sample_count, (i + 1) % 4);
      end
      tick(2);

      // 3: backpressure, third average dropped, overflow sticky
      avg_ready = 1'b0;
      exp_q.push_back(10'd1023);
      exp_q.push_back(10'd1023);
      for (int i = 0; i < 12; i++) conv(10'd1023, 1, 2);
      check("t3_overflow", overflow, 1);
      check("t3_valid", avg_valid, 1);
      check("t3_head", avg_result_digital, 1023);
      avg_ready = 1'b1;
      tick(3);
      check("t3_drained", avg_valid, 0);
      check("t3_overflow_hold", overflow, 1);
      clear_overflow = 1'b1;
      tick(1);
      clear_overflow = 1'b0;
      check("t3_overflow_clr", overflow, 0);

      // 4: full FIFO, pop in the cycle an average completes
      avg_ready = 1'b0;
      exp_q.push_back(10'd10);
      exp_q.push_back(10'd20);
      exp_q.push_back(10'd30);
      for (int i = 0; i < 4; i++) conv(10'd10, 1, 2);
      for (int i = 0; i < 4; i++) conv(10'd20, 1, 2);
      for (int i = 0; i < 3; i++) conv(10'd30, 1, 2);
      adc_result_digital = 10'd30;
      adc_eoc = 1'b1;
      avg_ready = 1'b1;
      tick(1);
      adc_eoc = 1'b0;
      check("t4_overflow", overflow, 0);
      check("t4_valid", avg_valid, 1);
      tick(4);

      // 5: enable drop discards the partial sum
      conv(10'd77, 1, 2);
      conv(10'd77, 1, 2);
      check("t5_partial", sample_count, 2);
      enable = 1'b0;
      tick(1);
      check("t5_cleared", sample_count, 0);
      conv(10'd999, 1, 2);
      check("t5_ignored", sample_count, 0);
      enable = 1'b1;
      exp_q.push_back(10'd200);
      for (int i = 0; i < 4; i++) conv(10'd200, 1, 2);
      tick(2);

      // 6: async reset mid-accumulation with an entry queued
      avg_ready = 1'b0;
      for (int i = 0; i < 4; i++) conv(10'd40, 1, 2);
      for (int i = 0; i < 3; i++) conv(10'd300, 1, 2);
      check("t6_queued", avg_valid, 1);
      check("t6_count", sample_count, 3);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_valid", avg_valid, 0);
      check("t6_rst_count", sample_count, 0);
      @(negedge clk) reset = 1'b1;
      tick(1);
      avg_ready = 1'b1;
      exp_q.push_back(10'd50);
      for (int i = 0; i < 4; i++) conv(10'd50, 1, 2);
      tick(3);

      check("all_outputs_seen", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
